// File: rtl/ysyx_25020037_scoreboard_pkg.sv
// Shared configuration for the issue scoreboard: GPR geometry, FSM encodings
// and performance-stall cause codes.
package ysyx_25020037_scoreboard_pkg;

  localparam int unsigned GPR_IDX_W = 4;
  localparam int unsigned NUM_GPR   = 16;
  localparam int unsigned INFL_W    = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } sb_state_e;

  localparam int unsigned PERF_RAW_STALL    = 0;
  localparam int unsigned PERF_SERIAL_STALL = 1;
  localparam int unsigned PERF_FULL_STALL   = 2;

endpackage

// File: rtl/ysyx_25020037_sb_cnt.sv
// One per-register pending-write counter; saturates at both ends so an
// illegal extra retire or issue can never wrap it.
module ysyx_25020037_sb_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic full_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);
  assign full_o = (cnt_q == '1);

  // Simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dec_i && !inc_i) begin
      assert (!zero_o);
    end
  end

endmodule

// File: rtl/ysyx_25020037_scoreboard.sv
// Decode->execute issue controller: GPR RAW/WAW tracking and serialisation.
// Optional stall statistics under YSYX_25020037_SCOREBOARD_PERF_EN.
module ysyx_25020037_scoreboard
  import ysyx_25020037_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [GPR_IDX_W-1:0] issue_rs1,
  input  logic [GPR_IDX_W-1:0] issue_rs2,
  input  logic                 issue_rs1_used,
  input  logic                 issue_rs2_used,
  input  logic [GPR_IDX_W-1:0] issue_rd,
  input  logic                 issue_we,
  input  logic                 issue_serial,
  input  logic                 exu_ready,
  output logic                 issue_ready,
  output logic                 issue_fire,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic                 wb_we,
  input  logic [GPR_IDX_W-1:0] wb_rd,
  output logic [INFL_W-1:0]    inflight,
  output logic [NUM_GPR-1:0]   busy_vec
);

  sb_state_e           state_q, state_d;
  logic [INFL_W-1:0]   inflight_q, inflight_d;
  logic [NUM_GPR-1:0]  pend_zero, pend_full, pend_inc, pend_dec;
  logic                hazard_c, infl_ok_c, base_c, ready_c, retire_ok_c;

  // Index 0 is instantiated but never driven, so x0 is permanently idle.
  for (genvar i = 0; i < int'(NUM_GPR); i++) begin : g_pend
    if (i == 0) begin : g_x0
      assign pend_inc[i] = 1'b0;
      assign pend_dec[i] = 1'b0;
    end else begin : g_gpr
      assign pend_inc[i] = issue_fire & issue_we & (issue_rd == GPR_IDX_W'(i));
      assign pend_dec[i] = wb_valid & wb_we & (wb_rd == GPR_IDX_W'(i));
    end
    ysyx_25020037_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (pend_inc[i]),
      .dec_i  (pend_dec[i]),
      .zero_o (pend_zero[i]),
      .full_o (pend_full[i])
    );
  end

  assign hazard_c = (issue_rs1_used & (issue_rs1 != '0) & ~pend_zero[issue_rs1])
                  | (issue_rs2_used & (issue_rs2 != '0) & ~pend_zero[issue_rs2])
                  | (issue_we & (issue_rd != '0) & pend_full[issue_rd]);
  assign infl_ok_c = (inflight_q < INFL_W'(MAX_INFLIGHT));
  assign base_c    = exu_ready & ~flush & ~hazard_c & infl_ok_c;

  assign issue_ready = ready_c & ~rst;
  assign issue_fire  = issue_valid & issue_ready;
  assign inflight    = inflight_q;
  assign busy_vec    = ~pend_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Serial candidates wait in DRAIN for an empty pipe, then own it in SERIAL.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (issue_serial && inflight_q != '0) begin
          if (issue_valid && !flush) state_d = ST_DRAIN;
        end else begin
          ready_c = base_c;
          if (issue_fire && issue_serial) state_d = ST_SERIAL;
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          state_d = ST_RUN;
        end else if (inflight_q == '0) begin
          ready_c = base_c;
          if (issue_fire) state_d = issue_serial ? ST_SERIAL : ST_RUN;
        end
      end
      ST_SERIAL: begin
        if (wb_valid && inflight_q == INFL_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign retire_ok_c = wb_valid & (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !retire_ok_c) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (!issue_fire && retire_ok_c) begin
      inflight_d = inflight_q - INFL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_valid) begin
      assert (inflight_q != '0);
    end
  end

`ifdef YSYX_25020037_SCOREBOARD_PERF_EN
  logic [31:0] raw_stall_cycles_q, serial_stall_cycles_q, full_stall_cycles_q;
  logic        stall_c, serial_cause_c, full_cause_c, raw_cause_c;

  assign stall_c        = issue_valid & ~issue_ready;
  assign serial_cause_c = (state_q != ST_RUN) | (issue_serial & (inflight_q != '0));
  assign full_cause_c   = ~serial_cause_c & ~infl_ok_c;
  assign raw_cause_c    = ~serial_cause_c & ~full_cause_c & hazard_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_stall_cycles_q    <= '0;
      serial_stall_cycles_q <= '0;
      full_stall_cycles_q   <= '0;
    end else if (stall_c) begin
      if (serial_cause_c) serial_stall_cycles_q <= serial_stall_cycles_q + 32'd1;
      if (full_cause_c)   full_stall_cycles_q   <= full_stall_cycles_q + 32'd1;
      if (raw_cause_c)    raw_stall_cycles_q    <= raw_stall_cycles_q + 32'd1;
    end
  end
`endif

endmodule
